// File: rtl/adc_chan_sequencer.sv
// Frame sequencer for the bolometer read-out: starts ADC conversions, reads one or two
// channels through the channel switch and streams captured pixels with position markers.
module adc_chan_sequencer #(
   parameter int unsigned ADC_WIDTH    = 14,
   parameter int unsigned PIX_PER_LINE = 320,
   parameter int unsigned LINES        = 240,
   parameter int unsigned CONV_CYCLES  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_start_i,
   input  logic                 numb_chan_i,
   input  logic [ADC_WIDTH-1:0] data_in_i,
   output logic                 adc_conv_o,
   output logic                 number_chan_o,
   output logic                 in_buf_en_o,
   output logic [ADC_WIDTH-1:0] pix_data_o,
   output logic                 pix_valid_o,
   input  logic                 pix_ready_i,
   output logic [8:0]           pix_x_o,
   output logic [7:0]           line_y_o,
   output logic                 line_end_o,
   output logic                 frame_end_o,
   output logic                 busy_o
);

   localparam int unsigned XW = 9;
   localparam int unsigned YW = 8;
   localparam int unsigned CW = 8;

   localparam logic [XW-1:0] X_LAST   = XW'(PIX_PER_LINE - 1);
   localparam logic [YW-1:0] Y_LAST   = YW'(LINES - 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(CONV_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CONV,
      S_WAIT,
      S_READ,
      S_CAPT,
      S_OUT
   } state_e;

   state_e               state_q;
   logic                 mode_q;
   logic                 ch_q;
   logic [CW-1:0]        cnt_q;
   logic                 adc_conv_q;
   logic                 number_chan_q;
   logic                 in_buf_en_q;
   logic [ADC_WIDTH-1:0] pix_data_q;
   logic                 pix_valid_q;
   logic [XW-1:0]        pix_x_q;
   logic [YW-1:0]        line_y_q;
   logic                 line_end_q;
   logic                 frame_end_q;
   logic                 busy_q;

   logic x_last;
   logic y_last;
   logic hs;

   assign x_last = (pix_x_q == X_LAST);
   assign y_last = (line_y_q == Y_LAST);
   assign hs     = pix_valid_q & pix_ready_i;

   // Outputs are loaded on the transition into the state that owns them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         mode_q        <= 1'b0;
         ch_q          <= 1'b0;
         cnt_q         <= '0;
         adc_conv_q    <= 1'b0;
         number_chan_q <= 1'b0;
         in_buf_en_q   <= 1'b0;
         pix_data_q    <= '0;
         pix_valid_q   <= 1'b0;
         pix_x_q       <= '0;
         line_y_q      <= '0;
         line_end_q    <= 1'b0;
         frame_end_q   <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         adc_conv_q  <= 1'b0;
         in_buf_en_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (frame_start_i) begin
                  mode_q     <= numb_chan_i;
                  ch_q       <= 1'b0;
                  pix_x_q    <= '0;
                  line_y_q   <= '0;
                  busy_q     <= 1'b1;
                  adc_conv_q <= 1'b1;
                  state_q    <= S_CONV;
               end
            end
            S_CONV: begin
               cnt_q   <= CNT_LOAD;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == '0) begin
                  number_chan_q <= ch_q;
                  in_buf_en_q   <= 1'b1;
                  state_q       <= S_READ;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            S_READ: begin
               state_q <= S_CAPT;
            end
            S_CAPT: begin
               pix_data_q    <= data_in_i;
               number_chan_q <= 1'b0;
               pix_valid_q   <= 1'b1;
               line_end_q    <= x_last;
               frame_end_q   <= x_last & y_last;
               state_q       <= S_OUT;
            end
            S_OUT: begin
               if (hs) begin
                  pix_valid_q <= 1'b0;
                  line_end_q  <= 1'b0;
                  frame_end_q <= 1'b0;
                  // Second channel was converted together with the first: read it directly.
                  if (mode_q && !ch_q) begin
                     ch_q          <= 1'b1;
                     pix_x_q       <= pix_x_q + XW'(1);
                     number_chan_q <= 1'b1;
                     in_buf_en_q   <= 1'b1;
                     state_q       <= S_READ;
                  end else begin
                     ch_q <= 1'b0;
                     if (x_last) begin
                        pix_x_q <= '0;
                        if (y_last) begin
                           line_y_q <= '0;
                           busy_q   <= 1'b0;
                           state_q  <= S_IDLE;
                        end else begin
                           line_y_q   <= line_y_q + YW'(1);
                           adc_conv_q <= 1'b1;
                           state_q    <= S_CONV;
                        end
                     end else begin
                        pix_x_q    <= pix_x_q + XW'(1);
                        adc_conv_q <= 1'b1;
                        state_q    <= S_CONV;
                     end
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign adc_conv_o    = adc_conv_q;
   assign number_chan_o = number_chan_q;
   assign in_buf_en_o   = in_buf_en_q;
   assign pix_data_o    = pix_data_q;
   assign pix_valid_o   = pix_valid_q;
   assign pix_x_o       = pix_x_q;
   assign line_y_o      = line_y_q;
   assign line_end_o    = line_end_q;
   assign frame_end_o   = frame_end_q;
   assign busy_o        = busy_q;

endmodule

// File: doc/adc_chan_sequencer.md
# adc_chan_sequencer

Frame-level controller for the bolometer read-out datapath. It starts ADC conversions, then reads one or both ADC channels through the channel switch by driving the channel select and buffer enable. It captures the selected sample and delivers pixels downstream with a valid/ready handshake, plus pixel/line coordinates and line/frame markers. It sits between the frame trigger logic and the channel switch on one side and the pixel FIFO/packer on the other.

## Interface
- PIX_PER_LINE, 320: pixels per line, counted over all channels; must be even when two channels are used.
- LINES, 240: lines per frame.
- CONV_CYCLES, 16: ADC conversion wait in clocks, 1..255.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- FRAME_START  in  1  single-cycle frame trigger.
- NUMB_CHAN  in  1  0 = one channel (channel 0 only), 1 = two channels; sampled on accepted FRAME_START.
- DATA_IN  in  `ADC_WIDHT  sample from the channel switch output.
- ADC_CONV  out  1  one-cycle conversion start, both ADCs.
- NUMBER_CHAN  out  1  channel select to the switch.
- IN_BUF_EN  out  1  read strobe to the switch.
- PIX_DATA  out  `ADC_WIDHT  captured pixel.
- PIX_VALID  out  1  pixel available.
- PIX_READY  in  1  downstream accepts.
- PIX_X  out  9  pixel index in line.
- LINE_Y  out  8  line index.
- LINE_END  out  1  marks the last pixel of a line; qualified by PIX_VALID.
- FRAME_END  out  1  marks the last pixel of a frame; qualified by PIX_VALID.
- BUSY  out  1  high from the accepted FRAME_START until the final handshake.

## Operation
- States: IDLE, CONV, WAIT, READ, CAPT, OUT.
- IDLE: FRAME_START=1 latches NUMB_CHAN into mode, clears PIX_X, LINE_Y and channel index ch, then goes to CONV. FRAME_START is ignored in every other state.
- CONV: ADC_CONV=1 for one cycle, then WAIT; the wait counter loads CONV_CYCLES-1.
- WAIT: counter decrements each cycle; goes to READ when it reaches 0.
- READ: NUMBER_CHAN=ch, IN_BUF_EN=1 for one cycle, then CAPT.
- CAPT: NUMBER_CHAN=ch held; PIX_DATA<=DATA_IN; then OUT.
- OUT: PIX_VALID=1. PIX_DATA, PIX_X, LINE_Y, LINE_END and FRAME_END are held stable until PIX_VALID&PIX_READY. On handshake:
  - If mode=1 and ch=0: ch<=1, PIX_X+1, go to READ. No new conversion; both channels were converted together.
  - Else ch<=0 and advance position:
    - PIX_X=PIX_PER_LINE-1: PIX_X<=0, LINE_Y+1.
    - Last line as well: LINE_Y<=0 and go to IDLE.
    - Otherwise PIX_X+1 and go to CONV.
- LINE_END=1 while in OUT when PIX_X=PIX_PER_LINE-1.
- FRAME_END=1 when LINE_END=1 and LINE_Y=LINES-1.
- NUMBER_CHAN=0 outside READ/CAPT.
- Mode is frozen for the whole frame; NUMB_CHAN changes mid-frame have no effect.

## Timing
- Reset values: ADC_CONV, IN_BUF_EN, NUMBER_CHAN, PIX_VALID, LINE_END, FRAME_END, BUSY = 0; PIX_DATA, PIX_X, LINE_Y = 0; state IDLE.
- Reset asserted mid-frame aborts immediately to the reset values, with no partial pixel output. After reset release, the block waits for a new FRAME_START.
- FRAME_START in cycle t gives ADC_CONV=1 in cycle t+1.
- ADC_CONV in cycle c gives IN_BUF_EN in cycle c+1+CONV_CYCLES and PIX_VALID in cycle c+3+CONV_CYCLES.
- Conversion period with PIX_READY held at 1:
  - one channel: CONV_CYCLES+4 clocks per pixel.
  - two channels: CONV_CYCLES+7 clocks per pixel pair.
- Each stall cycle (PIX_VALID=1, PIX_READY=0) adds one clock and changes no output.
- FRAME_START arriving in the same cycle as the final handshake is ignored; the next frame needs FRAME_START while in IDLE.
- BUSY falls in the cycle after the final handshake.

## Test plan
- One-channel frame, PIX_PER_LINE=4, LINES=2, CONV_CYCLES=3, DATA_IN = a counter:
  - 8 pixels, each with NUMBER_CHAN=0.
  - PIX_X sequence 0..3 twice, LINE_Y 0 then 1.
  - LINE_END on PIX_X=3; FRAME_END only on the 8th pixel.
  - ADC_CONV period 7 clocks.
- Same parameters, NUMB_CHAN=1:
  - 4 ADC_CONV pulses, 8 pixels with ch alternating 0,1.
  - One IN_BUF_EN per channel per conversion.
  - Conversion period 10 clocks.
- Backpressure: PIX_READY low for 5 cycles on pixel 2 -> PIX_VALID and PIX_DATA/PIX_X stable for those 5 cycles, no extra ADC_CONV, frame finishes 5 clocks later.
- FRAME_START pulses mid-frame and in the final handshake cycle -> ignored, exactly 8 pixels; a FRAME_START after BUSY=0 starts a new frame from (0,0).
- RST_N low during WAIT of pixel 3 -> all outputs 0 asynchronously; after release, no activity until FRAME_START, then the frame restarts at PIX_X=0.
- NUMB_CHAN toggled mid-frame -> mode unchanged until the next frame.
